// File: rtl/servant_vpu_pkg.sv
// Shared encodings for the servant VPU load/store unit: element widths,
// FSM states and the alignment rule applied to every command.
package servant_vpu_pkg;

  typedef enum logic [1:0] {
    SEW8    = 2'd0,
    SEW16   = 2'd1,
    SEW32   = 2'd2,
    SEW_BAD = 2'd3
  } sew_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  // True when the two address LSBs are a multiple of the element size.
  function automatic logic sew_aligned(input sew_e sew, input logic [1:0] lsb);
    case (sew)
      SEW8:    return 1'b1;
      SEW16:   return ~lsb[0];
      SEW32:   return lsb == 2'b00;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/servant_vpu_lane.sv
// Byte-lane steering between a 32-bit RAM word and one vector element:
// store packing (replicated data + byte enables) and load extraction.
module servant_vpu_lane
  import servant_vpu_pkg::*;
(
  input  sew_e        sew,
  input  logic [1:0]  st_off,
  input  logic [31:0] st_elem,
  output logic [31:0] st_dat,
  output logic [3:0]  st_sel,
  input  logic [1:0]  ld_off,
  input  logic [31:0] ld_word,
  output logic [31:0] ld_dat
);

  logic [31:0] shifted;

  always_comb begin
    // NOTE: defaults first so that every path through the case assigns every output (no latch).
    st_dat = st_elem;
    st_sel = 4'hF;
    case (sew)
      SEW8: begin
        st_dat = {4{st_elem[7:0]}};
        st_sel = 4'b0001 << st_off;
      end
      SEW16: begin
        st_dat = {2{st_elem[15:0]}};
        st_sel = st_off[1] ? 4'b1100 : 4'b0011;
      end
      default: ;
    endcase
  end

  assign shifted = ld_word >> {ld_off, 3'b000};

  always_comb begin
    ld_dat = shifted;
    case (sew)
      SEW8:    ld_dat = {24'h0, shifted[7:0]};
      SEW16:   ld_dat = {16'h0, shifted[15:0]};
      default: ;
    endcase
  end

endmodule

// File: rtl/servant_vpu_lsu.sv
// Strided vector load/store initiator on the servant RAM VPU port: one
// element access per cycle, load data written back to the VRF one cycle later.
module servant_vpu_lsu
  import servant_vpu_pkg::*;
#(
  parameter int aw    = 18,
  parameter int MAXVL = 32,
  parameter int vlw   = $clog2(MAXVL + 1),
  parameter int iw    = $clog2(MAXVL)
) (
  input  logic            i_wb_clk,
  input  logic            i_wb_rst_n,
  input  logic            i_cmd_valid,
  output logic            o_cmd_ready,
  input  logic            i_cmd_store,
  input  logic [1:0]      i_cmd_sew,
  input  logic [aw-1:0]   i_cmd_base,
  input  logic [31:0]     i_cmd_stride,
  input  logic [vlw-1:0]  i_cmd_vl,
  output logic            o_vpu_request_rd,
  output logic            o_vpu_request_wr,
  output logic [aw-3:0]   o_vpu_adr,
  output logic [31:0]     o_vpu_dat,
  output logic [3:0]      o_vpu_sel,
  input  logic [31:0]     i_ram_rdt,
  output logic [iw-1:0]   o_vrf_rd_idx,
  input  logic [31:0]     i_vrf_rd_dat,
  output logic            o_vrf_we,
  output logic [iw-1:0]   o_vrf_wr_idx,
  output logic [31:0]     o_vrf_wr_dat,
  output logic            o_busy,
  output logic            o_done,
  output logic            o_err
);

  state_e          state;
  logic            store_q;
  sew_e            sew_q;
  logic [aw-1:0]   a;
  logic [aw-1:0]   stride_q;
  logic [vlw-1:0]  vl_q;
  logic [vlw-1:0]  k;
  logic            err_q;
  logic            ld_valid;
  logic [1:0]      ld_off;
  logic [iw-1:0]   ld_idx;

  sew_e            cmd_sew;
  logic            cmd_legal;
  logic            last;
  logic            run;
  logic [31:0]     lane_st_dat;
  logic [3:0]      lane_st_sel;
  logic [31:0]     lane_ld_dat;
  logic            stride_hi_unused;

  assign cmd_sew   = sew_e'(i_cmd_sew);
  assign cmd_legal = sew_aligned(cmd_sew, i_cmd_base[1:0]) &&
                     sew_aligned(cmd_sew, i_cmd_stride[1:0]);
  assign last      = (k == vl_q - vlw'(1));
  assign run       = (state == S_RUN);

  // Addresses wrap modulo 2^aw, so stride bits above aw never matter.
  assign stride_hi_unused = ^i_cmd_stride[31:aw];

  always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
    if (!i_wb_rst_n) begin
      state    <= S_IDLE;
      store_q  <= 1'b0;
      sew_q    <= SEW8;
      a        <= '0;
      stride_q <= '0;
      vl_q     <= '0;
      k        <= '0;
      err_q    <= 1'b0;
      ld_valid <= 1'b0;
      ld_off   <= '0;
      ld_idx   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      ld_valid <= run && !store_q;
      ld_off   <= a[1:0];
      ld_idx   <= k[iw-1:0];
      case (state)
        S_IDLE: begin
          if (i_cmd_valid) begin
            store_q  <= i_cmd_store;
            sew_q    <= cmd_sew;
            a        <= i_cmd_base;
            stride_q <= i_cmd_stride[aw-1:0];
            vl_q     <= i_cmd_vl;
            k        <= '0;
            err_q    <= !cmd_legal;
            state    <= (!cmd_legal || i_cmd_vl == '0) ? S_DONE : S_RUN;
          end
        end
        S_RUN: begin
          a <= a + stride_q;
          k <= k + vlw'(1);
          if (last) state <= store_q ? S_DONE : S_DRAIN;
        end
        S_DRAIN: state <= S_DONE;
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  servant_vpu_lane u_lane (
    .sew     (sew_q),
    .st_off  (a[1:0]),
    .st_elem (i_vrf_rd_dat),
    .st_dat  (lane_st_dat),
    .st_sel  (lane_st_sel),
    .ld_off  (ld_off),
    .ld_word (i_ram_rdt),
    .ld_dat  (lane_ld_dat)
  );

  assign o_cmd_ready      = (state == S_IDLE);
  assign o_busy           = (state != S_IDLE);
  assign o_done           = (state == S_DONE);
  assign o_err            = o_done && err_q;
  assign o_vpu_request_rd = run && !store_q;
  assign o_vpu_request_wr = run && store_q;
  assign o_vpu_adr        = run ? a[aw-1:2] : '0;
  assign o_vpu_sel        = o_vpu_request_rd ? 4'hF :
                            o_vpu_request_wr ? lane_st_sel : 4'h0;
  assign o_vpu_dat        = o_vpu_request_wr ? lane_st_dat : '0;
  assign o_vrf_rd_idx     = k[iw-1:0];
  assign o_vrf_we         = ld_valid;
  assign o_vrf_wr_idx     = ld_idx;
  assign o_vrf_wr_dat     = ld_valid ? lane_ld_dat : '0;

endmodule

// File: tb/tb_servant_vpu_lsu.sv
// Bench for servant_vpu_lsu: byte-level memory model predicts every cycle of
// each command; a RAM and VRF around the DUT supply its data.
module tb_servant_vpu_lsu;
  import servant_vpu_pkg::*;

  localparam int AW    = 18;
  localparam int MAXVL = 32;
  localparam int VLW   = 6;
  localparam int IW    = 5;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              cmd_valid, cmd_ready, cmd_store;
  logic [1:0]        cmd_sew;
  logic [AW-1:0]     cmd_base;
  logic [31:0]       cmd_stride;
  logic [VLW-1:0]    cmd_vl;
  logic              req_rd, req_wr;
  logic [AW-3:0]     adr;
  logic [31:0]       dat;
  logic [3:0]        sel;
  logic [31:0]       ram_rdt;
  logic [IW-1:0]     rd_idx, wr_idx;
  logic [31:0]       vrf_rd_dat, wr_dat;
  logic              we, busy, done, err;

  always #5 clk = ~clk;

  servant_vpu_lsu dut (
    .i_wb_clk         (clk),
    .i_wb_rst_n       (rst_n),
    .i_cmd_valid      (cmd_valid),
    .o_cmd_ready      (cmd_ready),
    .i_cmd_store      (cmd_store),
    .i_cmd_sew        (cmd_sew),
    .i_cmd_base       (cmd_base),
    .i_cmd_stride     (cmd_stride),
    .i_cmd_vl         (cmd_vl),
    .o_vpu_request_rd (req_rd),
    .o_vpu_request_wr (req_wr),
    .o_vpu_adr        (adr),
    .o_vpu_dat        (dat),
    .o_vpu_sel        (sel),
    .i_ram_rdt        (ram_rdt),
    .o_vrf_rd_idx     (rd_idx),
    .i_vrf_rd_dat     (vrf_rd_dat),
    .o_vrf_we         (we),
    .o_vrf_wr_idx     (wr_idx),
    .o_vrf_wr_dat     (wr_dat),
    .o_busy           (busy),
    .o_done           (done),
    .o_err            (err)
  );

  // Environment: word RAM driven by the DUT, byte-level reference memory, VRF.
  bit   [31:0] ram  [0:(1<<(AW-2))-1];
  bit   [7:0]  mmem [0:(1<<AW)-1];
  logic [31:0] vrf  [0:MAXVL-1];

  assign vrf_rd_dat = vrf[rd_idx];

  always @(posedge clk) begin
    if (req_wr)
      for (int b = 0; b < 4; b++)
        if (sel[b]) ram[adr][8*b +: 8] <= dat[8*b +: 8];
    if (req_rd) ram_rdt <= ram[adr];
  end

  typedef struct {
    bit          ready, rd, wr, we, done, err;
    logic [15:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic [4:0]  ridx, widx;
    logic [31:0] wdat;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] cap_adr[$], cap_sel[$], cap_wdat[$];
  int          n_checks = 0;
  int          n_fail = 0;
  bit          chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t blank();
    exp_t e;
    e = '{default: 0};
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (chk_en) begin
      if (exp_q.size() > 0) e = exp_q.pop_front();
      else begin
        e = blank();
        e.ready = 1'b1;
      end
      check("cmd_ready", cmd_ready, e.ready);
      check("busy", busy, !e.ready);
      check("req_rd", req_rd, e.rd);
      check("req_wr", req_wr, e.wr);
      check("vrf_we", we, e.we);
      check("done", done, e.done);
      if (e.done) check("err", err, e.err);
      if (e.rd || e.wr) begin
        check("vpu_adr", adr, e.adr);
        check("vpu_sel", sel, e.sel);
      end
      if (e.wr) begin
        check("vpu_dat", dat, e.dat);
        check("vrf_rd_idx", rd_idx, e.ridx);
      end
      if (e.we) begin
        check("vrf_wr_idx", wr_idx, e.widx);
        check("vrf_wr_dat", wr_dat, e.wdat);
      end
      if (req_rd || req_wr) begin
        cap_adr.push_back(32'(adr));
        cap_sel.push_back(32'(sel));
      end
      if (we) cap_wdat.push_back(wr_dat);
    end
  end

  task automatic wait_idle();
    for (int i = 0; i < 200 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      check("idle_timeout", 32'(exp_q.size()), 0);
      exp_q.delete();
    end
  endtask

  task automatic clear_caps();
    cap_adr.delete();
    cap_sel.delete();
    cap_wdat.delete();
  endtask

  // Issues one command and queues what every following cycle must show.
  task automatic launch(input bit st, input bit [1:0] sew, input logic [AW-1:0] base,
                        input int stride, input int vl);
    exp_t        e;
    int          size;
    bit          legal;
    logic [31:0] t;
    logic [AW-1:0] ea  [MAXVL];
    logic [31:0]   lv  [MAXVL];
    logic [31:0]   sd  [MAXVL];
    logic [3:0]    ss  [MAXVL];
    logic [31:0]   elem;
    wait_idle();
    @(posedge clk); #1;
    cmd_valid  = 1'b1;
    cmd_store  = st;
    cmd_sew    = sew;
    cmd_base   = base;
    cmd_stride = 32'(stride);
    cmd_vl     = VLW'(vl);
    @(posedge clk); #1;
    cmd_valid  = 1'b0;
    cmd_store  = 1'($urandom);
    cmd_base   = AW'($urandom);
    size  = (sew == 2'd0) ? 1 : (sew == 2'd1) ? 2 : 4;
    legal = (sew != 2'd3) && ((int'(base) & (size - 1)) == 0) && ((stride & (size - 1)) == 0);
    if (!legal || vl == 0) begin
      e = blank();
      e.done = 1'b1;
      e.err  = !legal;
      exp_q.push_back(e);
      return;
    end
    for (int k = 0; k < vl; k++) begin
      t = 32'(base) + 32'(k * stride);
      ea[k] = t[AW-1:0];
      lv[k] = 0;
      for (int j = 0; j < size; j++) lv[k] |= 32'(mmem[ea[k] + AW'(j)]) << (8 * j);
      elem  = (size == 4) ? vrf[k] : vrf[k] & ((32'd1 << (8 * size)) - 1);
      sd[k] = (size == 1) ? {4{elem[7:0]}} : (size == 2) ? {2{elem[15:0]}} : elem;
      ss[k] = 4'(((1 << size) - 1) << ea[k][1:0]);
      if (st)
        for (int j = 0; j < size; j++) mmem[ea[k] + AW'(j)] = elem[8*j +: 8];
    end
    for (int c = 1; c <= vl + (st ? 1 : 2); c++) begin
      e = blank();
      if (c <= vl) begin
        e.rd   = !st;
        e.wr   = st;
        e.adr  = ea[c-1][AW-1:2];
        e.sel  = st ? ss[c-1] : 4'hF;
        e.dat  = sd[c-1];
        e.ridx = 5'(c - 1);
      end
      if (!st && c >= 2 && c <= vl + 1) begin
        e.we   = 1'b1;
        e.widx = 5'(c - 2);
        e.wdat = lv[c-2];
      end
      e.done = (c == vl + (st ? 1 : 2));
      exp_q.push_back(e);
    end
  endtask

  task automatic poke_word(input int waddr, input logic [31:0] v);
    ram[waddr] = v;
    for (int j = 0; j < 4; j++) mmem[4 * waddr + j] = v[8*j +: 8];
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: run still active, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] lit4 [4];
    int          mism;
    int          sz;
    bit   [1:0]  sew;
    logic [AW-1:0] base;
    int          stride, vl;
    cmd_valid = 0; cmd_store = 0; cmd_sew = 0; cmd_base = 0; cmd_stride = 0; cmd_vl = 0;
    for (int i = 0; i < MAXVL; i++) vrf[i] = $urandom;

    #2;
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_req", {req_rd, req_wr, we, done, err}, 0);
    check("rst_bus", {adr, sel, wr_idx, rd_idx}, 0);
    check("rst_dat", dat | wr_dat, 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1; chk_en = 1'b1;

    // Load sew32 from preloaded words.
    poke_word('h40, 32'h11); poke_word('h41, 32'h22);
    poke_word('h42, 32'h33); poke_word('h43, 32'h44);
    wait_idle(); clear_caps();
    launch(0, 2'd2, 'h100, 4, 4);
    wait_idle();
    lit4 = '{32'h11, 32'h22, 32'h33, 32'h44};
    check("lit_ld_count", 32'(cap_wdat.size()), 4);
    for (int i = 0; i < 4 && i < cap_wdat.size(); i++) check("lit_ld_dat", cap_wdat[i], lit4[i]);

    // Store sew8 into bytes 1..3 of word 0x200.
    wait_idle(); clear_caps();
    vrf[0] = 32'hFFFF_FFA1; vrf[1] = 32'h0000_12B2; vrf[2] = 32'h0000_00C3;
    launch(1, 2'd0, 'h201, 1, 3);
    wait_idle();
    lit4 = '{32'h2, 32'h4, 32'h8, 32'h0};
    check("lit_st8_count", 32'(cap_sel.size()), 3);
    for (int i = 0; i < 3 && i < cap_sel.size(); i++) check("lit_st8_sel", cap_sel[i], lit4[i]);
    check("lit_st8_word", ram['h80] >> 8, 32'hC3B2A1);

    // Store sew16 with negative stride inside one word.
    wait_idle(); clear_caps();
    vrf[0] = 32'h0000_BEEF; vrf[1] = 32'h0000_CAFE;
    launch(1, 2'd1, 'h302, -2, 2);
    wait_idle();
    check("lit_st16_count", 32'(cap_sel.size()), 2);
    if (cap_sel.size() == 2) begin
      check("lit_st16_sel0", cap_sel[0], 32'hC);
      check("lit_st16_sel1", cap_sel[1], 32'h3);
      check("lit_st16_adr0", cap_adr[0], 32'hC0);
      check("lit_st16_adr1", cap_adr[1], 32'hC0);
    end
    check("lit_st16_word", ram['hC0], 32'hBEEF_CAFE);

    // Misaligned command and empty command: no bus traffic.
    wait_idle(); clear_caps();
    launch(0, 2'd1, 'h101, 2, 4);
    launch(1, 2'd2, 'h100, 4, 0);
    wait_idle();
    check("lit_noreq", 32'(cap_adr.size()), 0);

    // Address wrap at the top of the RAM.
    wait_idle(); clear_caps();
    launch(0, 2'd2, 18'h3FFFC, 4, 2);
    wait_idle();
    check("lit_wrap_count", 32'(cap_adr.size()), 2);
    if (cap_adr.size() == 2) begin
      check("lit_wrap_adr0", cap_adr[0], 32'hFFFF);
      check("lit_wrap_adr1", cap_adr[1], 32'h0);
    end

    // Reset in the middle of a load.
    wait_idle();
    chk_en = 1'b0;
    @(posedge clk); #1;
    cmd_valid = 1; cmd_store = 0; cmd_sew = 2'd2; cmd_base = 'h400; cmd_stride = 4; cmd_vl = 20;
    @(posedge clk); #1;
    cmd_valid = 0;
    repeat (4) @(posedge clk);
    #2;
    check("mid_run_req", req_rd, 1);
    rst_n = 1'b0;
    #1;
    check("async_rst_req", {req_rd, req_wr}, 0);
    check("async_rst_busy", busy, 0);
    check("async_rst_ready", cmd_ready, 1);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1; chk_en = 1'b1;
    launch(0, 2'd2, 'h100, 4, 4);

    // Random commands.
    for (int n = 0; n < 60; n++) begin
      wait_idle();
      for (int i = 0; i < MAXVL; i++) vrf[i] = $urandom;
      sew  = ($urandom_range(0, 9) == 9) ? 2'd3 : 2'($urandom_range(0, 2));
      sz   = (sew == 2'd0) ? 1 : (sew == 2'd1) ? 2 : 4;
      base = AW'($urandom_range(0, 'h3FFF));
      if ($urandom_range(0, 7) != 0) base = base & ~AW'(sz - 1);
      stride = (int'($urandom_range(0, 16)) - 8) * sz;
      if ($urandom_range(0, 11) == 0) stride = stride + 1;
      vl = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, MAXVL));
      launch(1'($urandom), sew, base, stride, vl);
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end
    wait_idle();

    mism = 0;
    for (int w = 0; w < (1 << (AW - 2)); w++)
      if (ram[w] != {mmem[4*w+3], mmem[4*w+2], mmem[4*w+1], mmem[4*w]}) mism++;
    check("ram_image", 32'(mism), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/servant_vpu_lsu.md
# servant_vpu_lsu

Vector load/store initiator driving the VPU side port of the servant RAM (`i_vpu_request_rd/wr`, `i_vpu_adr`, `i_vpu_dat`, `i_vpu_sel`) and consuming its registered read data (`o_wb_rdt`). It accepts one strided vector memory command at a time from the VPU decoder and issues one element access per cycle. Load data goes to the vector register file (VRF); store data is read from the VRF. While busy it owns the RAM port, so the SoC must gate the CPU's `i_wb_cyc` with `o_busy`.

## Interface
- `aw`, 18: RAM byte-address width; matches the RAM's `aw`.
- `MAXVL`, 32: maximum elements per command.
- `vlw`, `$clog2(MAXVL+1)`: width of the vl field.
- `iw`, `$clog2(MAXVL)`: width of a VRF element index.

Ports:
- `i_wb_clk`  in  1  clock.
- `i_wb_rst_n`  in  1  reset, asynchronous, active-low.
- `i_cmd_valid`  in  1  command request.
- `o_cmd_ready`  out  1  high in IDLE only.
- `i_cmd_store`  in  1  1 = store, 0 = load.
- `i_cmd_sew`  in  2  element width: 0 = 8, 1 = 16, 2 = 32 bits; 3 is illegal.
- `i_cmd_base`  in  aw  byte base address.
- `i_cmd_stride`  in  32  signed byte stride.
- `i_cmd_vl`  in  vlw  element count, 0..MAXVL.
- `o_vpu_request_rd`, `o_vpu_request_wr`  out  1  RAM port requests.
- `o_vpu_adr`  out  aw-2  word address; equals byte address[aw-1:2].
- `o_vpu_dat`  out  32  store data.
- `o_vpu_sel`  out  4  byte enables.
- `i_ram_rdt`  in  32  RAM read data; valid the cycle after `request_rd`.
- `o_vrf_rd_idx`  out  iw  store element index; VRF read is combinational.
- `i_vrf_rd_dat`  in  32  store element data, LSB-aligned.
- `o_vrf_we`  out  1  load element write strobe.
- `o_vrf_wr_idx`  out  iw  load element index.
- `o_vrf_wr_dat`  out  32  load element data, zero-extended.
- `o_busy`  out  1  state != IDLE.
- `o_done`  out  1  one-cycle completion pulse.
- `o_err`  out  1  valid with `o_done`; indicates a misaligned or illegal command.

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- IDLE → RUN on `i_cmd_valid` when the command is legal and vl > 0. The command is latched and the element counter `k` is set to 0.
- A command is illegal when sew = 3, or when base or stride is not aligned to the sew byte size. An illegal command goes IDLE → DONE with `o_err` = 1; no RAM access is issued.
- vl = 0 goes IDLE → DONE with `o_err` = 0.
- RUN: one access per cycle at byte address `a`.
  - After each access: `a` ← `a` + stride (mod 2^aw, wraps), `k` ← `k` + 1.
  - Leave RUN after element vl-1. Loads go to DRAIN; stores go to DONE.
- Load, per element: `request_rd` = 1 and `sel` = 4'hF. Byte offset a[1:0] and `k` are pipelined one cycle. Next cycle: `o_vrf_we` = 1, `o_vrf_wr_idx` = k, `o_vrf_wr_dat` = (`i_ram_rdt` >> 8·off), masked to sew.
- Store, per element: `request_wr` = 1 and `o_vrf_rd_idx` = k.
  - sew8: dat = {4{b}}, sel = 1 << off.
  - sew16: dat = {2{h}}, sel = off[1] ? 4'b1100 : 4'b0011.
  - sew32: dat = word, sel = 4'hF.
- DRAIN: performs the final VRF write, then goes to DONE.
- DONE: `o_done` = 1 for one cycle, then IDLE.
- `i_cmd_valid` outside IDLE is ignored.
- Reset outputs: all outputs 0 except `o_cmd_ready` = 1. The state returns to IDLE immediately on reset assertion, including mid-command; partial stores remain in RAM.

## Timing
- Accept at edge E0. Requests are high in cycles 1..vl, with no gaps.
- Load VRF writes occur in cycles 2..vl+1 (the last one in DRAIN). `o_done` is in cycle vl+2.
- Store `o_done` is in cycle vl+1.
- `o_cmd_ready` returns in the cycle after `o_done`. Minimum command-to-command spacing is vl+3 cycles for loads and vl+2 for stores.
- `request_rd` and `request_wr` are never both high. `o_vrf_we` is never high in RUN cycle 1.

## Structure
- Package `servant_vpu_pkg` holds the sew encoding constants and the state encoding.
- Sub-module `servant_vpu_lane` (combinational) handles lane pack (dat/sel from sew, offset and element) and unpack (extract and zero-extend). It is shared by load and store paths.

## Test plan
- Load, sew32, base 0x100, stride 4, vl 4, RAM preloaded with 0x11..0x44 → VRF idx 0..3 = 0x11, 0x22, 0x33, 0x44 in cycles 2..5; `o_done` in cycle 6.
- Store, sew8, base 0x201, stride 1, vl 3, VRF = 0xA1, 0xB2, 0xC3 → sel 0010, 0100, 1000; word 0x200 reads 0xC3B2A1xx.
- Store, sew16, stride -2, base 0x302 → sel 1100 then 0011 at the same word.
- Illegal commands: sew16 with base 0x101 → `o_done` & `o_err` in cycle 1, no requests. Separately, vl = 0 → `o_done` with `o_err` = 0.
- Wrap: base 2^aw-4, stride 4, vl 2 → `o_vpu_adr` = max, then 0.
- Reset asserted mid-RUN → requests drop asynchronously; the next command is accepted normally.
